// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, bit-serial shifts and rotates,
// registered result with signed-overflow and zero flags.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    input  logic [SHW-1:0]   SHAMT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             Cout,
    output logic             Z
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_XNOR = 4'b0111;
    localparam logic [3:0] OP_IDA  = 4'b1000;
    localparam logic [3:0] OP_NOTA = 4'b1001;
    localparam logic [3:0] OP_LSR  = 4'b1010;
    localparam logic [3:0] OP_ASR  = 4'b1011;
    localparam logic [3:0] OP_ROR  = 4'b1100;
    localparam logic [3:0] OP_LSL  = 4'b1101;
    localparam logic [3:0] OP_ASL  = 4'b1110;
    localparam logic [3:0] OP_ROL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] c_q;
    logic             cout_q;
    logic             z_q;
    logic [WIDTH-1:0] w_q;
    logic [SHW-1:0]   cnt_q;
    logic [3:0]       op_q;
    logic             asl_q;

    logic [WIDTH-1:0] add_c;
    logic [WIDTH-1:0] sub_c;
    logic [WIDTH-1:0] alu_c;
    logic             ovf_c;
    logic             is_shift_c;
    logic [WIDTH-1:0] step_c;
    logic             flip_c;

    // Single-cycle result straight from the request operands
    always_comb begin
        add_c = A + B;
        sub_c = A - B;
        alu_c = A;
        ovf_c = 1'b0;
        case (OP)
            OP_ADD: begin
                alu_c = add_c;
                ovf_c = (A[MSB] == B[MSB]) && (add_c[MSB] != A[MSB]);
            end
            OP_SUB: begin
                alu_c = sub_c;
                ovf_c = (A[MSB] != B[MSB]) && (sub_c[MSB] != A[MSB]);
            end
            OP_AND:  alu_c = A & B;
            OP_OR:   alu_c = A | B;
            OP_NAND: alu_c = ~(A & B);
            OP_NOR:  alu_c = ~(A | B);
            OP_XOR:  alu_c = A ^ B;
            OP_XNOR: alu_c = ~(A ^ B);
            OP_IDA:  alu_c = A;
            OP_NOTA: alu_c = ~A;
            default: alu_c = A;
        endcase
    end

    assign is_shift_c = (OP >= OP_LSR);

    // One-bit step of the latched shift/rotate; flip_c flags an MSB change on a left shift
    always_comb begin
        step_c = w_q;
        case (op_q)
            OP_LSR:          step_c = {1'b0, w_q[MSB:1]};
            OP_ASR:          step_c = {w_q[MSB], w_q[MSB:1]};
            OP_ROR:          step_c = {w_q[0], w_q[MSB:1]};
            OP_LSL, OP_ASL:  step_c = {w_q[MSB-1:0], 1'b0};
            OP_ROL:          step_c = {w_q[MSB-1:0], w_q[MSB]};
            default:         step_c = w_q;
        endcase
    end

    assign flip_c = w_q[MSB] ^ w_q[MSB-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            cout_q      <= 1'b0;
            z_q         <= 1'b0;
            w_q         <= '0;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            asl_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        op_q       <= OP;
                        asl_q      <= 1'b0;
                        if (!is_shift_c) begin
                            c_q         <= alu_c;
                            cout_q      <= ovf_c;
                            z_q         <= (alu_c == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (SHAMT == '0) begin
                            c_q         <= A;
                            cout_q      <= 1'b0;
                            z_q         <= (A == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            w_q     <= A;
                            cnt_q   <= SHAMT;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    w_q   <= step_c;
                    cnt_q <= cnt_q - SHW'(1);
                    asl_q <= asl_q | flip_c;
                    // Last step publishes the result; C holds its old value until then
                    if (cnt_q == SHW'(1)) begin
                        c_q         <= step_c;
                        z_q         <= (step_c == '0);
                        cout_q      <= (op_q == OP_ASL) && (asl_q || flip_c);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign Cout      = cout_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16) with an arithmetic reference model and a per-cycle output checker.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  OP;
    logic [3:0]  SHAMT;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] C;
    logic        Cout;
    logic        Z;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [15:0] exp_c;
    logic        exp_cout;
    logic        exp_armed = 1'b0;

    alu_seq #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .OP(OP), .SHAMT(SHAMT),
        .out_valid(out_valid), .out_ready(out_ready),
        .C(C), .Cout(Cout), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: result of the whole operation from plain arithmetic; returns {cout, c}
    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input int s);
        logic [15:0] c;
        logic        v;
        int unsigned top;
        int unsigned all;
        v = 1'b0;
        case (op)
            4'd0: begin c = a + b; v = (a[15] == b[15]) && (c[15] != a[15]); end
            4'd1: begin c = a - b; v = (a[15] != b[15]) && (c[15] != a[15]); end
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = ~(a & b);
            4'd5: c = ~(a | b);
            4'd6: c = a ^ b;
            4'd7: c = ~(a ^ b);
            4'd8: c = a;
            4'd9: c = ~a;
            4'd10: c = a >> s;
            4'd11: c = 16'($signed(a) >>> s);
            4'd12: c = (s == 0) ? a : 16'((a >> s) | (a << (16 - s)));
            4'd13: c = a << s;
            4'd14: begin
                c = a << s;
                // MSB changes at some step unless bits [15:15-s] are all equal
                if (s > 0) begin
                    top = 32'(a) >> (15 - s);
                    all = (32'd1 << (s + 1)) - 32'd1;
                    v = !(top == 0 || top == all);
                end
            end
            default: c = (s == 0) ? a : 16'((a << s) | (a >> (16 - s)));
        endcase
        return {v, c};
    endfunction

    // Output checker: whenever a result is presented it must match the armed expectation
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_armed) begin
                chk("C", 32'(C), 32'(exp_c));
                chk("Cout", 32'(Cout), 32'(exp_cout));
                chk("Z", 32'(Z), 32'(exp_c == 16'h0));
            end else begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int s, input int bp);
        logic [16:0] m;
        int          lat;
        int          n;
        m        = model(op, a, b, s);
        exp_c    = m[15:0];
        exp_cout = m[16];
        lat      = (op >= 4'd10 && s > 0) ? s + 1 : 1;
        chk("in_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1; A = a; B = b; OP = op; SHAMT = 4'(s);
        exp_armed = 1'b1;
        @(posedge clk); #1;
        // Junk request held high; must be ignored until the next IDLE
        A = ~a; B = a ^ 16'h5A5A; OP = ~op; SHAMT = 4'(15 - s);
        n = 1;
        while (!out_valid && n < 40) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_armed = 1'b0;
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [16:0] m;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 16'h0; B = 16'h0; OP = 4'h0; SHAMT = 4'h0;

        // Pin the reference model against hand-computed values
        m = model(4'd0, 16'h7FFF, 16'h0001, 0);  chk("model_add_ovf", 32'(m), 32'h18000);
        m = model(4'd1, 16'h0005, 16'h0005, 0);  chk("model_sub_zero", 32'(m), 32'h00000);
        m = model(4'd12, 16'h0001, 16'h0, 4);    chk("model_ror", 32'(m), 32'h01000);
        m = model(4'd11, 16'h8000, 16'h0, 15);   chk("model_asr", 32'(m), 32'h0FFFF);
        m = model(4'd14, 16'h4000, 16'h0, 1);    chk("model_asl", 32'(m), 32'h18000);
        m = model(4'd13, 16'h4000, 16'h0, 1);    chk("model_lsl", 32'(m), 32'h08000);
        m = model(4'd15, 16'h8001, 16'h0, 4);    chk("model_rol", 32'(m), 32'h00018);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_C", 32'(C), 32'd0);
        chk("rst_Cout", 32'(Cout), 32'd0);
        chk("rst_Z", 32'(Z), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(4'd0,  16'h7FFF, 16'h0001, 0, 0);
        run_op(4'd1,  16'h0005, 16'h0005, 0, 0);
        run_op(4'd12, 16'h0001, 16'h0000, 4, 0);
        run_op(4'd11, 16'h8000, 16'h0000, 15, 0);
        run_op(4'd14, 16'h4000, 16'h0000, 1, 0);
        run_op(4'd13, 16'h4000, 16'h0000, 1, 0);
        run_op(4'd1,  16'h8000, 16'h0001, 0, 3);
        run_op(4'd4,  16'hF0F0, 16'hFF00, 0, 0);
        run_op(4'd7,  16'h1234, 16'h1234, 0, 1);
        run_op(4'd9,  16'hFFFF, 16'h0000, 0, 0);
        run_op(4'd8,  16'hBEEF, 16'h0000, 0, 0);
        run_op(4'd5,  16'h0F0F, 16'h00F0, 0, 0);
        run_op(4'd10, 16'h8421, 16'h0000, 3, 2);
        run_op(4'd15, 16'h8001, 16'h0000, 4, 0);
        run_op(4'd14, 16'h1000, 16'h0000, 4, 0);
        run_op(4'd14, 16'h0F00, 16'h0000, 3, 0);
        run_op(4'd11, 16'h4000, 16'h0000, 7, 0);
        run_op(4'd12, 16'hABCD, 16'h0000, 0, 0);

        // Reset in the middle of a ROL: nothing may be presented
        in_valid = 1'b1; A = 16'h0001; B = 16'h0; OP = 4'd15; SHAMT = 4'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_shift_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_C", 32'(C), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst2_idle_out_valid", 32'(out_valid), 32'd0);
        run_op(4'd0, 16'h0002, 16'h0003, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
